// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants, RS tag encodings and the result record
// carried from the execution units to the writeback stage.
package tomasulo_pkg;

   localparam int NUM_UNITS = 4;
   localparam int DATA_W    = 16;
   localparam int TAG_W     = 4;
   localparam int REG_AW    = 4;
   localparam int CNT_W     = 16;

   // Execution-unit slots on the CDB: two adders then two multipliers.
   localparam int UNIT_ADD0 = 0;
   localparam int UNIT_ADD1 = 1;
   localparam int UNIT_MUL0 = 2;
   localparam int UNIT_MUL1 = 3;

   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [REG_AW-1:0] rdest_t;

   // Tags above TAG_READY_MAX name an RS entry; at or below it means "value ready".
   localparam tag_t TAG_READY_MAX = 4'd7;
   localparam tag_t ADD_RS0       = 4'd8;
   localparam tag_t ADD_RS1       = 4'd9;
   localparam tag_t ADD_RS2       = 4'd10;
   localparam tag_t MUL_RS0       = 4'd11;
   localparam tag_t MUL_RS1       = 4'd12;
   localparam tag_t MUL_RS2       = 4'd13;

   typedef struct packed {
      data_t  data;
      tag_t   tag;
      rdest_t rdest;
   } result_t;

   // A result is only legal on the CDB if its tag names a real RS entry.
   function automatic logic tag_is_rs(input tag_t t);
      return t > TAG_READY_MAX;
   endfunction

endpackage

// File: rtl/cdb_writeback_if.sv
// Bundle between the execution units / register-status table and the
// writeback stage. The writeback stage is the slave; its environment the master.
interface cdb_writeback_if;
   import tomasulo_pkg::*;

   logic [NUM_UNITS-1:0]        res_valid;
   logic [NUM_UNITS*DATA_W-1:0] res_data;
   logic [NUM_UNITS*TAG_W-1:0]  res_tag;
   logic [NUM_UNITS*REG_AW-1:0] res_rdest;
   logic [NUM_UNITS-1:0]        res_ready;
   logic [REG_AW-1:0]           reg_stat_addr;
   logic [TAG_W-1:0]            reg_stat_tag;
   logic                        cdb_valid;
   logic [TAG_W-1:0]            cdb_tag;
   logic [DATA_W-1:0]           cdb_data;
   logic [REG_AW-1:0]           cdb_rdest;
   logic                        rf_we;
   logic                        rs_free;
   logic [CNT_W-1:0]            bcast_count;
   logic                        err_sticky;

   modport master (
      output res_valid, res_data, res_tag, res_rdest, reg_stat_tag,
      input  res_ready, reg_stat_addr, cdb_valid, cdb_tag, cdb_data,
             cdb_rdest, rf_we, rs_free, bcast_count, err_sticky
   );

   modport slave (
      input  res_valid, res_data, res_tag, res_rdest, reg_stat_tag,
      output res_ready, reg_stat_addr, cdb_valid, cdb_tag, cdb_data,
             cdb_rdest, rf_we, rs_free, bcast_count, err_sticky
   );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: scans requests starting at the pointer and
// grants the first one found; the pointer then moves just past the winner.
module rr_arbiter4 (
   input  logic       clock1,
   input  logic       reset_n,
   input  logic [3:0] i_req,
   output logic [3:0] o_grant,
   output logic [1:0] o_gnt_idx,
   output logic       o_gnt_any
);

   logic [1:0] r_rr_ptr;
   logic [1:0] w_scan;

   // Pick the first requester at or after the pointer, wrapping 3 -> 0.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      o_grant   = '0;
      o_gnt_idx = '0;
      o_gnt_any = 1'b0;
      w_scan    = '0;
      for (int k = 0; k < 4; k++) begin
         w_scan = r_rr_ptr + 2'(k);
         if (!o_gnt_any && i_req[w_scan]) begin
            o_grant[w_scan] = 1'b1;
            o_gnt_idx       = w_scan;
            o_gnt_any       = 1'b1;
         end
      end
   end

   // Advance the pointer past the winner; hold when nothing is granted.
   always_ff @(posedge clock1 or negedge reset_n) begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
      if (!reset_n)       r_rr_ptr <= '0;
      else if (o_gnt_any) r_rr_ptr <= o_gnt_idx + 2'd1;
   end

endmodule

// File: rtl/cdb_writeback.sv
// Writeback / CDB stage: one holding buffer per execution unit, round-robin
// arbitration to one broadcast per cycle, RS free on every broadcast and a
// register-file write only when the register status still names the producer.
module cdb_writeback
   import tomasulo_pkg::*;
(
   input  logic            clock1,
   input  logic            reset_n,
   cdb_writeback_if.slave  bus
);

   result_t              r_buf [NUM_UNITS];
   logic [NUM_UNITS-1:0] r_buf_valid;

   logic                 r_cdb_valid;
   tag_t                 r_cdb_tag;
   data_t                r_cdb_data;
   rdest_t               r_cdb_rdest;
   logic                 r_rf_we;
   logic                 r_rs_free;
   logic [CNT_W-1:0]     r_bcast_count;
   logic                 r_err_sticky;

   result_t              w_in [NUM_UNITS];
   logic [NUM_UNITS-1:0] w_ready;
   logic [NUM_UNITS-1:0] w_accept;
   logic [NUM_UNITS-1:0] w_load;
   logic                 w_illegal;
   logic [NUM_UNITS-1:0] w_grant;
   logic [1:0]           w_gnt_idx;
   logic                 w_gnt_any;
   result_t              w_gnt_buf;

   rr_arbiter4 u_arb (
      .clock1    (clock1),
      .reset_n   (reset_n),
      .i_req     (r_buf_valid),
      .o_grant   (w_grant),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_any (w_gnt_any)
   );

   // Unpack unit inputs; a buffer accepts when empty or being drained this cycle.
   always_comb begin
      w_illegal = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         w_in[i].data  = bus.res_data[i*DATA_W +: DATA_W];
         w_in[i].tag   = bus.res_tag[i*TAG_W +: TAG_W];
         w_in[i].rdest = bus.res_rdest[i*REG_AW +: REG_AW];
         w_ready[i]    = !r_buf_valid[i] || w_grant[i];
         w_accept[i]   = bus.res_valid[i] && w_ready[i];
         w_load[i]     = w_accept[i] && tag_is_rs(w_in[i].tag);
         if (w_accept[i] && !tag_is_rs(w_in[i].tag)) w_illegal = 1'b1;
      end
   end

   assign w_gnt_buf         = r_buf[w_gnt_idx];
   assign bus.res_ready     = w_ready;
   assign bus.reg_stat_addr = w_gnt_any ? w_gnt_buf.rdest : '0;

   // Buffer occupancy: drained by a grant, refilled by a legal accept (both may coincide).
   always_ff @(posedge clock1 or negedge reset_n) begin
      if (!reset_n) r_buf_valid <= '0;
      else          r_buf_valid <= (r_buf_valid & ~w_grant) | w_load;
   end

   // Buffer payload; only meaningful while its valid bit is set.
   always_ff @(posedge clock1) begin
      // NOTE: payload storage has no reset; the valid bits alone decide whether it is ever read.
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (w_load[i]) r_buf[i] <= w_in[i];
      end
   end

   // Broadcast registers, RS free / RF write strobes, counter and error flag.
   always_ff @(posedge clock1 or negedge reset_n) begin
      if (!reset_n) begin
         r_cdb_valid   <= 1'b0;
         r_cdb_tag     <= '0;
         r_cdb_data    <= '0;
         r_cdb_rdest   <= '0;
         r_rf_we       <= 1'b0;
         r_rs_free     <= 1'b0;
         r_bcast_count <= '0;
         r_err_sticky  <= 1'b0;
      end else begin
         r_cdb_valid <= w_gnt_any;
         r_rs_free   <= w_gnt_any;
         // A renamed destination still frees the RS but must not clobber the newer value.
         r_rf_we     <= w_gnt_any && (bus.reg_stat_tag == w_gnt_buf.tag);
         if (w_gnt_any) begin
            r_cdb_tag   <= w_gnt_buf.tag;
            r_cdb_data  <= w_gnt_buf.data;
            r_cdb_rdest <= w_gnt_buf.rdest;
            if (r_bcast_count != {CNT_W{1'b1}}) r_bcast_count <= r_bcast_count + 1'b1;
         end
         if (w_illegal) r_err_sticky <= 1'b1;
      end
   end

   assign bus.cdb_valid   = r_cdb_valid;
   assign bus.cdb_tag     = r_cdb_tag;
   assign bus.cdb_data    = r_cdb_data;
   assign bus.cdb_rdest   = r_cdb_rdest;
   assign bus.rf_we       = r_rf_we;
   assign bus.rs_free     = r_rs_free;
   assign bus.bcast_count = r_bcast_count;
   assign bus.err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: a cycle-by-cycle vector table covering
// contention, backpressure, stale tags and illegal tags, then a hand-written
// reset-mid-flight sequence.
module tb_cdb_writeback;
   import tomasulo_pkg::*;

   logic clock1  = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock1 = ~clock1;

   cdb_writeback_if bus();

   cdb_writeback dut (
      .clock1  (clock1),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Register-status table model, looked up combinationally like the real one.
   tag_t regstat [16];
   assign bus.reg_stat_tag = regstat[bus.reg_stat_addr];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [3:0]  valid;
      logic [63:0] data;
      logic [15:0] tag;
      logic [15:0] rdest;
      logic [3:0]  exp_rdy;
      logic [3:0]  exp_addr;
      logic        exp_cv;
      logic [3:0]  exp_tag;
      logic [15:0] exp_data;
      logic [3:0]  exp_rdest;
      logic        exp_we;
      logic [15:0] exp_cnt;
      logic        exp_err;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock1);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [63:0] d,
                        input logic [15:0] t, input logic [15:0] r);
      bus.res_valid = v;
      bus.res_data  = d;
      bus.res_tag   = t;
      bus.res_rdest = r;
   endtask

   function automatic vec_t row(input string nm, input logic [3:0] v, input logic [63:0] d,
                                input logic [15:0] t, input logic [15:0] r,
                                input logic [3:0] rdy, input logic [3:0] addr,
                                input logic cv, input logic [3:0] ct, input logic [15:0] cd,
                                input logic [3:0] cr, input logic we,
                                input logic [15:0] cnt, input logic err);
      vec_t x;
      x.name = nm; x.valid = v; x.data = d; x.tag = t; x.rdest = r;
      x.exp_rdy = rdy; x.exp_addr = addr; x.exp_cv = cv; x.exp_tag = ct;
      x.exp_data = cd; x.exp_rdest = cr; x.exp_we = we; x.exp_cnt = cnt; x.exp_err = err;
      return x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      logic [63:0] dA, dB, dB2, dC, dS, dE;
      logic [15:0] tA, tB, tB2, tC, tS, tE, rA, rB, rB2, rC, rS, rE;

      for (int i = 0; i < 16; i++) regstat[i] = '0;
      regstat[1] = ADD_RS0;  regstat[2]  = ADD_RS1;  regstat[3]  = ADD_RS0;
      regstat[4] = ADD_RS0;  regstat[5]  = ADD_RS1;  regstat[6]  = MUL_RS0;
      regstat[7] = MUL_RS1;  regstat[9]  = MUL_RS0;  regstat[10] = MUL_RS2;
      regstat[11] = MUL_RS1; regstat[12] = MUL_RS1;

      // Payloads, unit 3 in the top slice.
      dA  = {16'h00d3, 16'h00d2, 16'h00d1, 16'h00d0};
      tA  = {4'd12, 4'd11, 4'd9, 4'd8};   rA  = {4'd7, 4'd6, 4'd5, 4'd4};
      dB  = {16'h0b03, 16'h0b02, 16'h0b01, 16'h0b00};
      tB  = {4'd13, 4'd11, 4'd9, 4'd8};   rB  = {4'd10, 4'd9, 4'd2, 4'd1};
      dB2 = {16'h0, 16'h0b22, 32'h0};
      tB2 = {4'd0, 4'd12, 8'h0};          rB2 = {4'd0, 4'd11, 8'h0};
      dC  = {48'h0, 16'h0012};
      tC  = {12'h0, 4'd8};                rC  = {12'h0, 4'd3};
      dS  = {32'h0, 16'h0bad, 16'h0};
      tS  = {8'h0, 4'd10, 4'd0};          rS  = {8'h0, 4'd12, 4'd0};
      dE  = {32'h0, 16'h5555, 16'h0};
      tE  = {8'h0, 4'd5, 4'd0};           rE  = {8'h0, 4'd2, 4'd0};

      //               name      drive: v      data  tag  rdest  expect: rdy  addr cv tag   data     rd   we cnt  err
      vecs[0]  = row("a_idle",  4'hF, dA,  tA,  rA,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd0,  0);
      vecs[1]  = row("a_g0",    4'h0, '0,  '0,  '0,  4'h1, 4'd4,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd0,  0);
      vecs[2]  = row("a_b0",    4'h0, '0,  '0,  '0,  4'h3, 4'd5,  1, 4'd8,  16'h00d0, 4'd4,  1, 16'd1,  0);
      vecs[3]  = row("a_b1",    4'h0, '0,  '0,  '0,  4'h7, 4'd6,  1, 4'd9,  16'h00d1, 4'd5,  1, 16'd2,  0);
      vecs[4]  = row("a_b2",    4'h0, '0,  '0,  '0,  4'hF, 4'd7,  1, 4'd11, 16'h00d2, 4'd6,  1, 16'd3,  0);
      vecs[5]  = row("a_b3",    4'h0, '0,  '0,  '0,  4'hF, 4'd0,  1, 4'd12, 16'h00d3, 4'd7,  1, 16'd4,  0);
      vecs[6]  = row("b_idle",  4'hF, dB,  tB,  rB,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd4,  0);
      vecs[7]  = row("b_g0",    4'h4, dB2, tB2, rB2, 4'h1, 4'd1,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd4,  0);
      vecs[8]  = row("b_b0",    4'h4, dB2, tB2, rB2, 4'h3, 4'd2,  1, 4'd8,  16'h0b00, 4'd1,  1, 16'd5,  0);
      vecs[9]  = row("b_b1",    4'h4, dB2, tB2, rB2, 4'h7, 4'd9,  1, 4'd9,  16'h0b01, 4'd2,  1, 16'd6,  0);
      vecs[10] = row("b_b2a",   4'h0, '0,  '0,  '0,  4'hB, 4'd10, 1, 4'd11, 16'h0b02, 4'd9,  1, 16'd7,  0);
      vecs[11] = row("b_b3",    4'h0, '0,  '0,  '0,  4'hF, 4'd11, 1, 4'd13, 16'h0b03, 4'd10, 1, 16'd8,  0);
      vecs[12] = row("b_b2b",   4'h0, '0,  '0,  '0,  4'hF, 4'd0,  1, 4'd12, 16'h0b22, 4'd11, 1, 16'd9,  0);
      vecs[13] = row("c_idle",  4'h1, dC,  tC,  rC,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd9,  0);
      vecs[14] = row("c_g",     4'h0, '0,  '0,  '0,  4'hF, 4'd3,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd9,  0);
      vecs[15] = row("c_b",     4'h2, dS,  tS,  rS,  4'hF, 4'd0,  1, 4'd8,  16'h0012, 4'd3,  1, 16'd10, 0);
      vecs[16] = row("s_g",     4'h0, '0,  '0,  '0,  4'hF, 4'd12, 0, 4'd0,  16'h0000, 4'd0,  0, 16'd10, 0);
      vecs[17] = row("s_b",     4'h2, dE,  tE,  rE,  4'hF, 4'd0,  1, 4'd10, 16'h0bad, 4'd12, 0, 16'd11, 0);
      vecs[18] = row("e_set",   4'h0, '0,  '0,  '0,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd11, 1);
      vecs[19] = row("e_hold",  4'h0, '0,  '0,  '0,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd11, 1);
      vecs[20] = row("e_hold2", 4'h0, '0,  '0,  '0,  4'hF, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 16'd11, 1);

      // Power-on reset.
      drive('0, '0, '0, '0);
      reset_n = 1'b0;
      step();
      step();
      check("rst_cdb_valid", 32'(bus.cdb_valid),   32'd0);
      check("rst_cdb_tag",   32'(bus.cdb_tag),     32'd0);
      check("rst_cdb_data",  32'(bus.cdb_data),    32'd0);
      check("rst_cdb_rdest", 32'(bus.cdb_rdest),   32'd0);
      check("rst_rf_we",     32'(bus.rf_we),       32'd0);
      check("rst_rs_free",   32'(bus.rs_free),     32'd0);
      check("rst_count",     32'(bus.bcast_count), 32'd0);
      check("rst_err",       32'(bus.err_sticky),  32'd0);
      check("rst_ready",     32'(bus.res_ready),   32'hF);
      reset_n = 1'b1;

      // Each row: check the outputs of this cycle, then drive this cycle's inputs.
      for (int i = 0; i < NV; i++) begin
         step();
         check($sformatf("%s_ready", vecs[i].name), 32'(bus.res_ready),     32'(vecs[i].exp_rdy));
         check($sformatf("%s_addr",  vecs[i].name), 32'(bus.reg_stat_addr), 32'(vecs[i].exp_addr));
         check($sformatf("%s_valid", vecs[i].name), 32'(bus.cdb_valid),     32'(vecs[i].exp_cv));
         check($sformatf("%s_free",  vecs[i].name), 32'(bus.rs_free),       32'(vecs[i].exp_cv));
         check($sformatf("%s_we",    vecs[i].name), 32'(bus.rf_we),         32'(vecs[i].exp_we));
         check($sformatf("%s_count", vecs[i].name), 32'(bus.bcast_count),   32'(vecs[i].exp_cnt));
         check($sformatf("%s_err",   vecs[i].name), 32'(bus.err_sticky),    32'(vecs[i].exp_err));
         if (vecs[i].exp_cv) begin
            check($sformatf("%s_tag",   vecs[i].name), 32'(bus.cdb_tag),   32'(vecs[i].exp_tag));
            check($sformatf("%s_data",  vecs[i].name), 32'(bus.cdb_data),  32'(vecs[i].exp_data));
            check($sformatf("%s_rdest", vecs[i].name), 32'(bus.cdb_rdest), 32'(vecs[i].exp_rdest));
         end
         if (i == 6) check("a_rr_ptr_wrap", 32'(dut.u_arb.r_rr_ptr), 32'(UNIT_ADD0));
         drive(vecs[i].valid, vecs[i].data, vecs[i].tag, vecs[i].rdest);
      end

      // Reset mid-flight: three results in, first broadcast out, then reset.
      drive(4'h7, {16'h0, 16'h0c02, 16'h0c01, 16'h0c00}, {4'd0, 4'd11, 4'd9, 4'd8},
            {4'd0, 4'd9, 4'd2, 4'd1});
      step();
      drive('0, '0, '0, '0);
      step();
      check("mid_pre_busy", 32'(bus.res_ready[UNIT_MUL0] | bus.res_ready[UNIT_ADD0]
                                | bus.res_ready[UNIT_ADD1]), 32'd1);
      step();
      check("mid_pre_valid", 32'(bus.cdb_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.cdb_valid),   32'd0);
      check("mid_rst_tag",   32'(bus.cdb_tag),     32'd0);
      check("mid_rst_data",  32'(bus.cdb_data),    32'd0);
      check("mid_rst_rdest", 32'(bus.cdb_rdest),   32'd0);
      check("mid_rst_we",    32'(bus.rf_we),       32'd0);
      check("mid_rst_free",  32'(bus.rs_free),     32'd0);
      check("mid_rst_count", 32'(bus.bcast_count), 32'd0);
      check("mid_rst_err",   32'(bus.err_sticky),  32'd0);
      check("mid_rst_ready", 32'(bus.res_ready),   32'hF);
      step();
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("mid_quiet%0d_valid", k), 32'(bus.cdb_valid), 32'd0);
         check($sformatf("mid_quiet%0d_count", k), 32'(bus.bcast_count), 32'd0);
      end
      drive(4'h1, {48'h0, 16'h0777}, {12'h0, 4'd8}, {12'h0, 4'd3});
      step();
      drive('0, '0, '0, '0);
      check("mid_new_c1_valid", 32'(bus.cdb_valid), 32'd0);
      step();
      check("mid_new_c2_valid", 32'(bus.cdb_valid),   32'd1);
      check("mid_new_c2_tag",   32'(bus.cdb_tag),     32'd8);
      check("mid_new_c2_data",  32'(bus.cdb_data),    32'h0777);
      check("mid_new_c2_rdest", 32'(bus.cdb_rdest),   32'd3);
      check("mid_new_c2_we",    32'(bus.rf_we),       32'd1);
      check("mid_new_c2_count", 32'(bus.bcast_count), 32'd1);
      step();
      check("mid_new_c3_valid", 32'(bus.cdb_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
